// File: rtl/scroll_feeder.sv
// scroll_feeder -- loads a short message of display codes and scrolls it
// right-to-left through a DIGITS-wide window, one position per prescaler tick.
//
// The scrolled stream is DIGITS blanks followed by the L stored characters,
// repeating with period L+DIGITS. Digit 0 is the leftmost display digit.
//
// Build option: define SCROLL_PAUSE_EN to add the pause input, which freezes
// the prescaler, position and window while high.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   msg_start  pulse: abort current message, clear window, start loading
//   wr_valid   character write request (honoured only while loading)
//   wr_data    5-bit code: 0-15 hex glyph, 16 blank, 17-31 stored as blank
//   wr_last    marks wr_data as the final character of the message
//   pause      (SCROLL_PAUSE_EN only) freeze scrolling
//   wr_ready   high while loading
//   win_data   DIGITS x 5-bit window, digit k at bits [5k+4:5k]
//   win_valid  one-cycle pulse whenever win_data takes a new scroll frame
//   busy       high whenever not idle
//   pos        current scroll position
module scroll_feeder #(
  parameter int DIGITS = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                msg_start,
  input  logic                wr_valid,
  input  logic [4:0]          wr_data,
  input  logic                wr_last,
`ifdef SCROLL_PAUSE_EN
  input  logic                pause,
`endif
  output logic                wr_ready,
  output logic [5*DIGITS-1:0] win_data,
  output logic                win_valid,
  output logic                busy,
  output logic [4:0]          pos
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  // Wide enough for pos + k, which stays below twice the period.
  localparam int SW    = $clog2(DEPTH + 2 * DIGITS);

  localparam logic [4:0]          BLANK     = 5'd16;
  localparam logic [5*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCROLL = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [4:0]          pos_reg, pos_next, pos_tick;
  logic [DIV_W-1:0]    presc_reg, presc_next;
  logic [5*DIGITS-1:0] win_reg, win_next, win_calc;
  logic                win_valid_reg, win_valid_next;
  logic [4:0]          mem_reg [DEPTH];
  logic                wr_en;
  logic                paused;
  logic [SW-1:0]       period;
  logic [4:0]          wr_code;

`ifdef SCROLL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign period  = SW'(len_reg) + SW'(DIGITS);
  assign wr_code = (wr_data > BLANK) ? BLANK : wr_data;

  // Position the next tick moves to; wraps at the end of the stream.
  assign pos_tick = (SW'(pos_reg) == period - SW'(1)) ? 5'd0 : pos_reg + 5'd1;

  // Window contents for pos_tick, so a tick updates pos and the window on
  // the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_win
      logic [SW-1:0] sum;
      logic [SW-1:0] idx;
      logic [SW-1:0] off;
      assign sum = SW'(pos_tick) + SW'(gi);
      assign idx = (sum >= period) ? sum - period : sum;
      assign off = idx - SW'(DIGITS);
      assign win_calc[gi*5 +: 5] = (idx < SW'(DIGITS)) ? BLANK : mem_reg[off[AW-1:0]];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    pos_next       = pos_reg;
    presc_next     = presc_reg;
    win_next       = win_reg;
    win_valid_next = 1'b0;
    wr_en          = 1'b0;
    if (msg_start) begin
      // Restart wins over anything else, including a coincident write.
      state_next = LOAD;
      len_next   = '0;
      pos_next   = 5'd0;
      presc_next = '0;
      win_next   = ALL_BLANK;
    end else begin
      case (state_reg)
        LOAD: begin
          if (wr_valid) begin
            wr_en    = 1'b1;
            len_next = len_reg + LEN_W'(1);
            if (wr_last || (len_reg == LEN_W'(DEPTH - 1))) begin
              state_next     = SCROLL;
              pos_next       = 5'd0;
              presc_next     = '0;
              win_next       = ALL_BLANK;
              win_valid_next = 1'b1;
            end
          end
        end
        SCROLL: begin
          if (!paused) begin
            presc_next = presc_reg + DIV_W'(1);
            if (presc_reg == '1) begin
              pos_next       = pos_tick;
              win_next       = win_calc;
              win_valid_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      pos_reg       <= 5'd0;
      presc_reg     <= '0;
      win_reg       <= ALL_BLANK;
      win_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      pos_reg       <= pos_next;
      presc_reg     <= presc_next;
      win_reg       <= win_next;
      win_valid_reg <= win_valid_next;
    end
  end

  // Message storage; only indices below L are ever read, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[len_reg[AW-1:0]] <= wr_code;
    end
  end

  assign wr_ready  = (state_reg == LOAD);
  assign busy      = (state_reg != IDLE);
  assign win_data  = win_reg;
  assign win_valid = win_valid_reg;
  assign pos       = pos_reg;

endmodule

// File: tb/tb_scroll_feeder.sv
// Bench for scroll_feeder at DIV_W=4 (tick every 16 clocks), DIGITS=8,
// DEPTH=16. A behavioural model of the message stream is compared against
// the DUT on every falling edge; directed scenarios add literal checks.
module tb_scroll_feeder;
  localparam int DIGITS = 8;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 4;
  localparam int W      = 5 * DIGITS;
  localparam int TICK   = 1 << DIV_W;
  localparam logic [W-1:0] ALLB = {DIGITS{5'd16}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_start = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_last = 1'b0;
  logic         pause = 1'b0;
  logic [4:0]   wr_data = 5'd0;
  logic         wr_ready, win_valid, busy;
  logic [W-1:0] win_data;
  logic [4:0]   pos;

  always #5 clk = ~clk;

  scroll_feeder #(.DIGITS(DIGITS), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .msg_start(msg_start),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_last(wr_last),
`ifdef SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .wr_ready(wr_ready),
    .win_data(win_data),
    .win_valid(win_valid),
    .busy(busy),
    .pos(pos)
  );

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 loading, 2 scrolling
  int           m_state = 0;
  int           m_len = 0;
  int           m_pos = 0;
  int           m_cnt = 0;
  bit           m_valid = 1'b0;
  logic [4:0]   m_msg [DEPTH];
  logic [W-1:0] m_win = ALLB;

  // Window seen at position p of the stream "DIGITS blanks, then message".
  function automatic logic [W-1:0] window(input int p);
    logic [W-1:0] w;
    int per;
    int s;
    per = m_len + DIGITS;
    for (int k = 0; k < DIGITS; k++) begin
      s = (p + k) % per;
      w[5*k +: 5] = (s < DIGITS) ? 5'd16 : m_msg[s - DIGITS];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_len   <= 0;
      m_pos   <= 0;
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_win   <= ALLB;
    end else begin
      m_valid <= 1'b0;
      if (msg_start) begin
        m_state <= 1;
        m_len   <= 0;
        m_pos   <= 0;
        m_cnt   <= 0;
        m_win   <= ALLB;
      end else if (m_state == 1 && wr_valid) begin
        m_msg[m_len] <= (wr_data > 5'd16) ? 5'd16 : wr_data;
        m_len <= m_len + 1;
        if (wr_last || (m_len + 1 == DEPTH)) begin
          m_state <= 2;
          m_pos   <= 0;
          m_cnt   <= 0;
          m_valid <= 1'b1;
          m_win   <= ALLB;
        end
      end else if (m_state == 2 && !pause) begin
        if (m_cnt == TICK - 1) begin
          m_cnt   <= 0;
          m_pos   <= (m_pos + 1) % (m_len + DIGITS);
          m_win   <= window((m_pos + 1) % (m_len + DIGITS));
          m_valid <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {63'd0, busy}, {63'd0, m_state != 0});
      chk("wr_ready", {63'd0, wr_ready}, {63'd0, m_state == 1});
      chk("win_valid", {63'd0, win_valid}, {63'd0, m_valid});
      chk("win_data", 64'(win_data), 64'(m_win));
      if (m_state != 1) chk("pos", 64'(pos), 64'(m_pos));
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+2) ----------------
  task automatic wr(input logic [4:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    @(posedge clk); #2;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic start_msg();
    msg_start = 1'b1;
    @(posedge clk); #2;
    msg_start = 1'b0;
  endtask

  task automatic start_with_write(input logic [4:0] d);
    msg_start = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = d;
    @(posedge clk); #2;
    msg_start = 1'b0;
    wr_valid  = 1'b0;
  endtask

  // Counts falling edges until win_valid is seen, then realigns.
  task automatic wait_tick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!win_valid && c < 64);
    if (!win_valid) begin
      n_checks++;
      $display("FAIL tick_timeout: no win_valid within %0d cycles", c);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int c;
    int nv;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd0);
    chk("rst_valid", 64'(win_valid), 64'd0);
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_win", 64'(win_data), 64'(ALLB));
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Write while idle is ignored
    wr(5'd3, 1'b1);
    chk("idle_write_busy", 64'(busy), 64'd0);

    // Message 1,7,0,1 (P=12)
    start_msg();
    chk("a_load_ready", 64'(wr_ready), 64'd1);
    wr(5'd1, 1'b0); wr(5'd7, 1'b0); wr(5'd0, 1'b0); wr(5'd1, 1'b1);
    chk("a_ready_after_last", 64'(wr_ready), 64'd0);
    wait_tick(c);
    chk("a_entry_latency", 64'(c), 64'd1);
    chk("a_entry_win", 64'(win_data), 64'(ALLB));
    wait_tick(c);
    chk("a_tick_period", 64'(c), 64'd16);
    chk("a_t1_win", 64'(win_data), 64'({5'd1, {7{5'd16}}}));
    repeat (7) wait_tick(c);
    chk("a_t8_pos", 64'(pos), 64'd8);
    chk("a_t8_win", 64'(win_data), 64'({{4{5'd16}}, 5'd1, 5'd0, 5'd7, 5'd1}));
    repeat (4) wait_tick(c);
    chk("a_t12_pos", 64'(pos), 64'd0);
    chk("a_t12_win", 64'(win_data), 64'(ALLB));

    // 16 characters, no last flag; codes 17 and 31 store as blank (P=24)
    start_msg();
    for (int i = 0; i < 16; i++) begin
      wr((i < 14) ? 5'(i) : ((i == 14) ? 5'd17 : 5'd31), 1'b0);
    end
    chk("b_ready_full", 64'(wr_ready), 64'd0);
    chk("b_busy", 64'(busy), 64'd1);
    wait_tick(c);
    wr(5'd4, 1'b1);
    for (int t = 1; t <= 24; t++) begin
      wait_tick(c);
      if (t == 21) chk("b_t21_win", 64'(win_data), 64'({{7{5'd16}}, 5'd13}));
      if (t == 23) begin
        chk("b_t23_pos", 64'(pos), 64'd23);
        chk("b_t23_win", 64'(win_data), 64'(ALLB));
      end
    end
    chk("b_wrap_pos", 64'(pos), 64'd0);

    // Restart mid-scroll at pos 5
    repeat (5) wait_tick(c);
    chk("c_pos5", 64'(pos), 64'd5);
    start_msg();
    chk("c_busy", 64'(busy), 64'd1);
    chk("c_ready", 64'(wr_ready), 64'd1);
    chk("c_win", 64'(win_data), 64'(ALLB));

    // Restart coincident with a write at L=3; message becomes 5,6 (P=10)
    wr(5'd7, 1'b0); wr(5'd8, 1'b0); wr(5'd9, 1'b0);
    start_with_write(5'd9);
    wr(5'd5, 1'b0); wr(5'd6, 1'b1);
    wait_tick(c);
    wait_tick(c);
    chk("d_t1_win", 64'(win_data), 64'({5'd5, {7{5'd16}}}));
    wait_tick(c);
    chk("d_t2_win", 64'(win_data), 64'({5'd6, 5'd5, {6{5'd16}}}));
    repeat (8) wait_tick(c);
    chk("d_wrap_pos", 64'(pos), 64'd0);

    // Asynchronous reset mid-scroll
    repeat (2) wait_tick(c);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_async_busy", 64'(busy), 64'd0);
    chk("e_async_ready", 64'(wr_ready), 64'd0);
    chk("e_async_valid", 64'(win_valid), 64'd0);
    chk("e_async_pos", 64'(pos), 64'd0);
    chk("e_async_win", 64'(win_data), 64'(ALLB));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("e_busy_after_release", 64'(busy), 64'd0);

`ifdef SCROLL_PAUSE_EN
    // Pause 40 cycles at pos 3 with 6 prescaler counts already taken
    start_msg();
    wr(5'd2, 1'b0); wr(5'd3, 1'b1);
    wait_tick(c);
    repeat (3) wait_tick(c);
    chk("p_pos3", 64'(pos), 64'd3);
    repeat (5) @(posedge clk);
    #2;
    pause = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (win_valid) nv++;
    end
    @(posedge clk); #2;
    pause = 1'b0;
    chk("p_pos_frozen", 64'(pos), 64'd3);
    chk("p_no_valid", 64'(nv), 64'd0);
    wait_tick(c);
    chk("p_resume_cycles", 64'(c), 64'd10);
    chk("p_pos4", 64'(pos), 64'd4);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
